// File: rtl/conv_col_feeder_if.sv
// Bundle between conv_col_feeder and its producer/consumer: kernel start,
// pixel stream handshake and the conv_2d column outputs.
interface conv_col_feeder_if #(
  parameter int DATA_W = 8
);
  logic                  i_knl_start;
  logic [9*DATA_W-1:0]   i_kernel;
  logic                  i_valid;
  logic [DATA_W-1:0]     i_pixel;
  logic                  o_ready;
  logic                  o_load_knl;
  logic                  o_en_conv;
  logic [DATA_W-1:0]     o_data1;
  logic [DATA_W-1:0]     o_data2;
  logic [DATA_W-1:0]     o_data3;
  logic                  o_frame_done;

  modport slave (
    input  i_knl_start,
    input  i_kernel,
    input  i_valid,
    input  i_pixel,
    output o_ready,
    output o_load_knl,
    output o_en_conv,
    output o_data1,
    output o_data2,
    output o_data3,
    output o_frame_done
  );

  modport master (
    output i_knl_start,
    output i_kernel,
    output i_valid,
    output i_pixel,
    input  o_ready,
    input  o_load_knl,
    input  o_en_conv,
    input  o_data1,
    input  o_data2,
    input  o_data3,
    input  o_frame_done
  );
endinterface

// File: rtl/conv_col_feeder.sv
// Feeds conv_2d: loads a 3x3 kernel as 3 columns, then turns a raster
// pixel stream into 3-row columns using two line buffers.
// Ports: clk, i_nrst (async active-low), bus (conv_col_feeder_if.slave).
module conv_col_feeder #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic               clk,
  input  logic               i_nrst,
  conv_col_feeder_if.slave   bus
);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PRIME,
    S_STREAM
  } state_e;

  state_e              state_q, state_d;
  logic [9*DATA_W-1:0] knl_q, knl_d;
  logic [1:0]          j_q, j_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                ready_q, ready_d;
  logic                load_q, load_d;
  logic                en_q, en_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   d1_q, d1_d;
  logic [DATA_W-1:0]   d2_q, d2_d;
  logic [DATA_W-1:0]   d3_q, d3_d;

  logic [DATA_W-1:0]   lb0_q [IMG_WIDTH];
  logic [DATA_W-1:0]   lb1_q [IMG_WIDTH];

  logic acc;
  logic lb_we;
  logic last_col;
  logic last_row;

  // k_n, n = 1..9, row-major
  function automatic logic [DATA_W-1:0] coef(
    input logic [9*DATA_W-1:0] k,
    input int                  n
  );
    return k[n*DATA_W-1 -: DATA_W];
  endfunction

  assign acc      = bus.i_valid & ready_q;
  assign last_col = (col_q == COL_W'(IMG_WIDTH - 1));
  assign last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));

  always_comb begin
    state_d = state_q;
    knl_d   = knl_q;
    j_d     = j_q;
    col_d   = col_q;
    row_d   = row_q;
    load_d  = 1'b0;
    en_d    = 1'b0;
    done_d  = 1'b0;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    lb_we   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_knl_start) begin
          knl_d   = bus.i_kernel;
          j_d     = 2'd0;
          load_d  = 1'b1;
          d1_d    = coef(bus.i_kernel, 1);
          d2_d    = coef(bus.i_kernel, 4);
          d3_d    = coef(bus.i_kernel, 7);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // j_q is the column currently on the outputs
        if (j_q == 2'd2) begin
          state_d = S_PRIME;
        end else begin
          j_d    = j_q + 2'd1;
          load_d = 1'b1;
          d1_d   = coef(knl_q, 2 + int'(j_q));
          d2_d   = coef(knl_q, 5 + int'(j_q));
          d3_d   = coef(knl_q, 8 + int'(j_q));
        end
      end
      S_PRIME: begin
        if (acc) begin
          lb_we = 1'b1;
          if (last_col) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == ROW_W'(1)) begin
              state_d = S_STREAM;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (acc) begin
          lb_we = 1'b1;
          en_d  = 1'b1;
          d1_d  = lb0_q[col_q];
          d2_d  = lb1_q[col_q];
          d3_d  = bus.i_pixel;
          if (last_col && last_row) begin
            done_d  = 1'b1;
            col_d   = '0;
            row_d   = '0;
            state_d = S_IDLE;
          end else if (last_col) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // ready tracks the state the outputs will belong to
    ready_d = (state_d == S_PRIME) || (state_d == S_STREAM);
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= S_IDLE;
      knl_q   <= '0;
      j_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ready_q <= 1'b0;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
    end else begin
      state_q <= state_d;
      knl_q   <= knl_d;
      j_q     <= j_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ready_q <= ready_d;
      load_q  <= load_d;
      en_q    <= en_d;
      done_q  <= done_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
    end
  end

  // Line buffers are fully written during PRIME before any read,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= bus.i_pixel;
    end
  end

  assign bus.o_ready      = ready_q;
  assign bus.o_load_knl   = load_q;
  assign bus.o_en_conv    = en_q;
  assign bus.o_data1      = d1_q;
  assign bus.o_data2      = d2_q;
  assign bus.o_data3      = d3_q;
  assign bus.o_frame_done = done_q;
endmodule

// File: tb/tb_conv_col_feeder.sv
// Directed bench for conv_col_feeder, 4x3 frames, pixel(r,c) = 16*r + c.
// Kernel load, priming, column stream, backpressure, ignored start, reset.
module tb_conv_col_feeder;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  conv_col_feeder_if #(.DATA_W(DW)) bus ();

  conv_col_feeder #(
    .DATA_W    (DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk   (clk),
    .i_nrst(nrst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_knl_start = 1'b0;
    bus.i_kernel    = '0;
    bus.i_valid     = 1'b0;
    bus.i_pixel     = '0;
    #1 nrst = 1'b0;
    #2;
    checks++;
    if ({bus.o_ready, bus.o_load_knl, bus.o_en_conv, bus.o_frame_done}
        !== 4'b0000) begin
      failures++;
      $display("FAIL rst_ctrl: got %b want 0000",
        {bus.o_ready, bus.o_load_knl, bus.o_en_conv, bus.o_frame_done});
    end
    checks++;
    if ({bus.o_data1, bus.o_data2, bus.o_data3} !== 24'h0) begin
      failures++;
      $display("FAIL rst_data: got %h want 000000",
        {bus.o_data1, bus.o_data2, bus.o_data3});
    end
    #9 nrst = 1'b1;
    step();
    checks++;
    if ({bus.o_ready, bus.o_load_knl} !== 2'b00) begin
      failures++;
      $display("FAIL rst_idle: got %b want 00",
        {bus.o_ready, bus.o_load_knl});
    end
  endtask

  task automatic test_kernel_load();
    logic [23:0] exp_col [3];
    exp_col[0] = 24'h00_80_00;
    exp_col[1] = 24'h80_05_80;
    exp_col[2] = 24'h00_80_00;
    // {k9..k1}
    bus.i_kernel = {8'h00, 8'h80, 8'h00, 8'h80, 8'h05,
                    8'h80, 8'h00, 8'h80, 8'h00};
    bus.i_knl_start = 1'b1;
    step();
    bus.i_knl_start = 1'b0;
    bus.i_kernel    = '1;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({bus.o_load_knl, bus.o_ready, bus.o_en_conv} !== 3'b100) begin
        failures++;
        $display("FAIL load_ctrl%0d: got %b want 100", j,
          {bus.o_load_knl, bus.o_ready, bus.o_en_conv});
      end
      checks++;
      if ({bus.o_data1, bus.o_data2, bus.o_data3} !== exp_col[j]) begin
        failures++;
        $display("FAIL load_col%0d: got %h want %h", j,
          {bus.o_data1, bus.o_data2, bus.o_data3}, exp_col[j]);
      end
      step();
    end
    checks++;
    if ({bus.o_load_knl, bus.o_ready, bus.o_en_conv} !== 3'b010) begin
      failures++;
      $display("FAIL load_end: got %b want 010",
        {bus.o_load_knl, bus.o_ready, bus.o_en_conv});
    end
  endtask

  task automatic test_priming(input bit pulse_start);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < W; c++) begin
        bus.i_valid = 1'b1;
        bus.i_pixel = 8'(16 * r + c);
        bus.i_knl_start = pulse_start && r == 0 && c == 2;
        step();
        bus.i_knl_start = 1'b0;
        checks++;
        if ({bus.o_en_conv, bus.o_load_knl, bus.o_ready} !== 3'b001) begin
          failures++;
          $display("FAIL prime_r%0dc%0d: got %b want 001", r, c,
            {bus.o_en_conv, bus.o_load_knl, bus.o_ready});
        end
      end
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic test_stream();
    logic [23:0] exp_d;
    for (int c = 0; c < W; c++) begin
      bus.i_valid = 1'b1;
      bus.i_pixel = 8'(8'h20 + c);
      step();
      exp_d = {8'(c), 8'(8'h10 + c), 8'(8'h20 + c)};
      checks++;
      if ({bus.o_data1, bus.o_data2, bus.o_data3} !== exp_d) begin
        failures++;
        $display("FAIL col%0d: got %h want %h", c,
          {bus.o_data1, bus.o_data2, bus.o_data3}, exp_d);
      end
      checks++;
      if ({bus.o_en_conv, bus.o_frame_done, bus.o_ready}
          !== {1'b1, c == W - 1, c != W - 1}) begin
        failures++;
        $display("FAIL col%0d_ctrl: got %b want %b", c,
          {bus.o_en_conv, bus.o_frame_done, bus.o_ready},
          {1'b1, c == W - 1, c != W - 1});
      end
    end
    bus.i_valid = 1'b0;
    step();
    checks++;
    if ({bus.o_en_conv, bus.o_frame_done, bus.o_ready, bus.o_load_knl}
        !== 4'b0000) begin
      failures++;
      $display("FAIL post_frame: got %b want 0000",
        {bus.o_en_conv, bus.o_frame_done, bus.o_ready, bus.o_load_knl});
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] exp_d;
    for (int t = 0; t < W + 2; t++) begin
      int c;
      bit hole;
      hole = (t == 2 || t == 3);
      c = (t < 2) ? t : t - 2;
      bus.i_valid = !hole;
      bus.i_pixel = hole ? 8'hAA : 8'(8'h20 + c);
      step();
      if (hole) begin
        exp_d = 24'h01_11_21;
        checks++;
        if ({bus.o_en_conv, bus.o_frame_done} !== 2'b00) begin
          failures++;
          $display("FAIL bp_hole%0d_ctrl: got %b want 00", t,
            {bus.o_en_conv, bus.o_frame_done});
        end
      end else begin
        exp_d = {8'(c), 8'(8'h10 + c), 8'(8'h20 + c)};
        checks++;
        if ({bus.o_en_conv, bus.o_frame_done} !== {1'b1, c == W - 1}) begin
          failures++;
          $display("FAIL bp_col%0d_ctrl: got %b want %b", c,
            {bus.o_en_conv, bus.o_frame_done}, {1'b1, c == W - 1});
        end
      end
      checks++;
      if ({bus.o_data1, bus.o_data2, bus.o_data3} !== exp_d) begin
        failures++;
        $display("FAIL bp_data%0d: got %h want %h", t,
          {bus.o_data1, bus.o_data2, bus.o_data3}, exp_d);
      end
    end
    bus.i_valid = 1'b0;
    step();
    checks++;
    if (bus.o_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_end_ready: got %b want 0", bus.o_ready);
    end
  endtask

  task automatic test_ignored_start();
    test_kernel_load();
    test_priming(1'b1);
    test_backpressure();
  endtask

  task automatic test_async_reset();
    test_kernel_load();
    test_priming(1'b0);
    bus.i_valid = 1'b1;
    bus.i_pixel = 8'h20;
    step();
    bus.i_valid = 1'b0;
    checks++;
    if ({bus.o_en_conv, bus.o_data1, bus.o_data2, bus.o_data3}
        !== {1'b1, 24'h00_10_20}) begin
      failures++;
      $display("FAIL ar_col0: got %h want 1001020",
        {bus.o_en_conv, bus.o_data1, bus.o_data2, bus.o_data3});
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({bus.o_ready, bus.o_load_knl, bus.o_en_conv, bus.o_frame_done,
         bus.o_data1, bus.o_data2, bus.o_data3} !== 28'h0) begin
      failures++;
      $display("FAIL ar_outputs: got %h want 0",
        {bus.o_ready, bus.o_load_knl, bus.o_en_conv, bus.o_frame_done,
         bus.o_data1, bus.o_data2, bus.o_data3});
    end
    step();
    #2 nrst = 1'b1;
    step();
    checks++;
    if ({bus.o_ready, bus.o_load_knl, bus.o_frame_done} !== 3'b000) begin
      failures++;
      $display("FAIL ar_idle: got %b want 000",
        {bus.o_ready, bus.o_load_knl, bus.o_frame_done});
    end
    test_kernel_load();
    test_priming(1'b0);
    test_stream();
  endtask

  initial begin
    test_reset();
    test_kernel_load();
    test_priming(1'b0);
    test_stream();
    test_ignored_start();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
